// File: rtl/receive.sv
// 8N1 UART receiver: two-flop input synchronizer feeding an IDLE/START/DATA/STOP
// state machine that samples mid-bit and reports good frames or bad stop bits.
module receive #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connection_status,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       valid,
  output logic       frame_error
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
  logic          armed_r;
  logic          sync_r;
  logic          rxd_s;

  // Two-flop synchronizer for the asynchronous serial line, reset to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      sync_r <= rxd;
      rxd_s  <= sync_r;
    end
  end

  // Receive state machine with registered word and single-cycle status pulses.
  // armed_r blocks a stuck-low line after a framing error from retriggering
  // until the line has been seen high while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      armed_r     <= 1'b1;
      word        <= 8'h00;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      valid       <= 1'b0;
      frame_error <= 1'b0;
      if (!connection_status) begin
        state_r <= IDLE;
        cnt_r   <= '0;
        idx_r   <= 3'd0;
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r <= '0;
            idx_r <= 3'd0;
            if (rxd_s) begin
              armed_r <= 1'b1;
            end else if (armed_r) begin
              state_r <= START;
            end else begin
              state_r <= IDLE;
            end
          end
          START: begin
            if (cnt_r == CNT_MID) begin
              cnt_r   <= '0;
              state_r <= rxd_s ? IDLE : DATA;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          DATA: begin
            if (cnt_r == CNT_LAST) begin
              cnt_r          <= '0;
              shift_r[idx_r] <= rxd_s;
              if (idx_r == 3'd7) begin
                idx_r   <= 3'd0;
                state_r <= STOP;
              end else begin
                idx_r <= idx_r + 3'd1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          STOP: begin
            // Leaving at mid stop bit leaves room for a start bit right behind it.
            if (cnt_r == CNT_LAST) begin
              cnt_r   <= '0;
              state_r <= IDLE;
              if (rxd_s) begin
                word  <= shift_r;
                valid <= 1'b1;
              end else begin
                frame_error <= 1'b1;
                armed_r     <= 1'b0;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receive.sv
// Directed bench for the UART receiver at CLKS_PER_BIT=16.
module tb_receive;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       connection_status = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] word;
  logic       valid;
  logic       frame_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_both = 0;
  int n_long = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] words[$];

  receive #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .connection_status(connection_status),
    .rxd(rxd),
    .word(word),
    .valid(valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      words.push_back(word);
      last_valid_cyc <= cyc;
    end
    if (frame_error) n_ferr <= n_ferr + 1;
    if (valid && frame_error) n_both <= n_both + 1;
    if ((valid && prev_valid) || (frame_error && prev_ferr)) n_long <= n_long + 1;
    prev_valid <= valid;
    prev_ferr <= frame_error;
  end

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, output int e0);
    e0 = cyc + 1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(data[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (word !== 8'h00) begin failures++; $display("FAIL reset_word: got %h expected %h", word, 8'h00); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", frame_error); end
    rst = 1'b0;
    drive_bit(1'b1, 10);
    checks++; if (n_valid !== 0 || n_ferr !== 0) begin failures++; $display("FAIL reset_idle_pulses: got v=%0d fe=%0d expected 0 0", n_valid, n_ferr); end
  endtask

  task automatic test_single;
    int e0, v0, f0, lat;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, 1'b1, e0);
    drive_bit(1'b1, 20);
    lat = last_valid_cyc - e0;
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL single_valid_count: got %0d expected 1", n_valid - v0); end
    checks++; if (word !== 8'h81) begin failures++; $display("FAIL single_word: got %h expected %h", word, 8'h81); end
    checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL single_ferr: got %0d expected 0", n_ferr - f0); end
    checks++; if (lat < 154 || lat > 156) begin failures++; $display("FAIL single_latency: got %0d expected 154..156", lat); end
  endtask

  task automatic test_back_to_back;
    int e0, v0, f0, w0;
    v0 = n_valid; f0 = n_ferr; w0 = words.size();
    send_frame(8'h81, 1'b1, e0);
    send_frame(8'h00, 1'b1, e0);
    drive_bit(1'b1, 20);
    checks++; if (n_valid - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0); end
    if (words.size() >= w0 + 2) begin
      checks++; if (words[w0] !== 8'h81) begin failures++; $display("FAIL b2b_word0: got %h expected %h", words[w0], 8'h81); end
      checks++; if (words[w0+1] !== 8'h00) begin failures++; $display("FAIL b2b_word1: got %h expected %h", words[w0+1], 8'h00); end
    end else begin
      checks++; failures++; $display("FAIL b2b_words: got %0d words expected 2", words.size() - w0);
    end
    checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL b2b_ferr: got %0d expected 0", n_ferr - f0); end
  endtask

  task automatic test_frame_error;
    int e0, v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b0, e0);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 200);
    checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin failures++; $display("FAIL ferr_valid: got %0d expected 0", n_valid - v0); end
    checks++; if (word !== 8'h00) begin failures++; $display("FAIL ferr_word_held: got %h expected %h", word, 8'h00); end
  endtask

  task automatic test_glitch;
    int e0, v0, f0;
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin failures++; $display("FAIL glitch_pulses: got v=%0d fe=%0d expected 0 0", n_valid - v0, n_ferr - f0); end
    send_frame(8'h3C, 1'b1, e0);
    drive_bit(1'b1, 20);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL glitch_follow_count: got %0d expected 1", n_valid - v0); end
    checks++; if (word !== 8'h3C) begin failures++; $display("FAIL glitch_follow_word: got %h expected %h", word, 8'h3C); end
  endtask

  task automatic test_disconnect;
    int e0, v0, f0;
    logic [7:0] d;
    d = 8'h55;
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        drive_bit(d[i], CPB / 2);
        connection_status = 1'b0;
        drive_bit(d[i], CPB / 2);
      end else begin
        drive_bit(d[i], CPB);
      end
    end
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 20);
    connection_status = 1'b1;
    drive_bit(1'b1, 20);
    checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin failures++; $display("FAIL disc_pulses: got v=%0d fe=%0d expected 0 0", n_valid - v0, n_ferr - f0); end
    send_frame(d, 1'b1, e0);
    drive_bit(1'b1, 20);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL disc_follow_count: got %0d expected 1", n_valid - v0); end
    checks++; if (word !== 8'h55) begin failures++; $display("FAIL disc_follow_word: got %h expected %h", word, 8'h55); end
  endtask

  task automatic test_reset_mid_frame;
    int e0, v0, f0;
    logic [7:0] d;
    d = 8'hE7;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        drive_bit(d[i], CPB / 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (word !== 8'h00) begin failures++; $display("FAIL rstmid_word: got %h expected %h", word, 8'h00); end
        checks++; if (valid !== 1'b0 || frame_error !== 1'b0) begin failures++; $display("FAIL rstmid_pulses: got v=%b fe=%b expected 0 0", valid, frame_error); end
        v0 = n_valid; f0 = n_ferr;
        drive_bit(d[i], CPB / 2 - 1);
      end else begin
        drive_bit(d[i], CPB);
      end
    end
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 20);
    checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin failures++; $display("FAIL rstmid_aborted: got v=%0d fe=%0d expected 0 0", n_valid - v0, n_ferr - f0); end
    send_frame(8'h96, 1'b1, e0);
    drive_bit(1'b1, 20);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL rstmid_follow_count: got %0d expected 1", n_valid - v0); end
    checks++; if (word !== 8'h96) begin failures++; $display("FAIL rstmid_follow_word: got %h expected %h", word, 8'h96); end
  endtask

  task automatic test_pulse_shape;
    checks++; if (n_both !== 0) begin failures++; $display("FAIL pulse_overlap: got %0d expected 0", n_both); end
    checks++; if (n_long !== 0) begin failures++; $display("FAIL pulse_width: got %0d long pulses expected 0", n_long); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_disconnect();
    test_reset_mid_frame();
    test_pulse_shape();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/receive.md
RECEIVE -- requirements
Module: receive

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit period; legal values are even and >= 8.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 connection_status  input  1  1 = link enabled; 0 = receiver held idle.
REQ-005 rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-006 word  output  8  last correctly framed data byte.
REQ-007 valid  output  1  one-cycle pulse when word is updated.
REQ-008 frame_error  output  1  one-cycle pulse when a frame has a bad stop bit.

Function
REQ-009 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-010 rxd SHALL pass through a 2-flop synchronizer (rxd_s) before any use; this adds exactly 2 cycles of latency.
REQ-011 The FSM states SHALL be IDLE, START, DATA and STOP, with one bit counter (0..CLKS_PER_BIT-1) and one data index (0..7).
REQ-012 IDLE: when rxd_s=0 and connection_status=1 -> START, and the bit counter clears.
REQ-013 START: at counter = CLKS_PER_BIT/2-1 (mid start bit), if rxd_s=0 -> DATA with the counter cleared; otherwise -> IDLE as a glitch, with no output pulse.
REQ-014 DATA: at counter = CLKS_PER_BIT-1, sample rxd_s into shift bit [index] and clear the counter; after index 7 -> STOP.
REQ-015 STOP: at counter = CLKS_PER_BIT-1 (mid stop bit), sample rxd_s and go -> IDLE in the same cycle.
REQ-016 Stop sample = 1: word SHALL load the shifted byte, and valid SHALL be 1 for exactly the next cycle.
REQ-017 Stop sample = 0: word SHALL NOT change, and frame_error SHALL be 1 for exactly the next cycle.
REQ-018 valid and frame_error SHALL never be high in the same cycle.
REQ-019 word SHALL hold its value until the next good frame; no handshake and no overrun detection.
REQ-020 Returning to IDLE at mid stop bit SHALL allow a back-to-back frame whose start bit immediately follows the stop bit to be received.
REQ-021 connection_status=0 in any state SHALL force IDLE on the next edge, discard the partial frame and emit no pulse.
REQ-022 A frame-error line held low SHALL NOT retrigger a frame until rxd_s has been seen high in IDLE at least once.
REQ-023 Latency: valid SHALL rise 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+-1) after the first clk edge that samples rxd low.

Reset
REQ-024 When rst=1 at a clk edge: state=IDLE, counters=0, shift register=0, word=8'h00, valid=0, frame_error=0, and both synchronizer flops=1.
REQ-025 rst SHALL take priority over all other inputs, including mid-frame; no pulse SHALL be emitted for an aborted frame.

Verification (CLKS_PER_BIT=16, bits driven 16 clk each)
REQ-026 Frame for 8'd129 (0x81) -> word=0x81, a single valid pulse, frame_error stays 0.
REQ-027 0x81 immediately followed by 0x00, no idle gap -> two valid pulses, with word=0x81 then word=0x00.
REQ-028 0xA5 with stop bit driven 0 -> frame_error pulses once, word keeps its prior value, no valid.
REQ-029 rxd low for 4 clk then high -> no valid and no frame_error; a following good frame 0x3C is received correctly.
REQ-030 connection_status dropped during data bit 3 of 0x55 -> no pulse; after re-enable, 0x55 is received correctly.
REQ-031 rst pulsed for 1 cycle during data bit 5 -> all outputs are at reset values the next cycle, and the next frame is received correctly.
